// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Brief    : AHB round-robin bus arbiter with fixed-burst hold and lock retention.
// Revision : 1.0
// ============================================================================
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BURST  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  arb_state_t      state;
  logic [4:0]      count;
  logic [MW-1:0]   owner;

  logic            fixed_burst;
  logic [4:0]      burst_load;
  arb_state_t      trk_state;
  logic [4:0]      trk_count;
  logic            rearb;
  logic            lock_keep;
  logic            rr_found;
  logic [MW-1:0]   rr_next;
  logic [MW-1:0]   cand;

  // Counter preload is burst length minus one; SINGLE/INCR open no burst.
  always_comb begin
    fixed_burst = 1'b1;
    burst_load  = 5'd0;
    case (HBURST)
      3'b010, 3'b011: burst_load = 5'd3;
      3'b100, 3'b101: burst_load = 5'd7;
      3'b110, 3'b111: burst_load = 5'd15;
      default:        fixed_burst = 1'b0;
    endcase
  end

  always_comb begin
    trk_state = state;
    trk_count = count;
    rearb     = 1'b0;
    case (state)
      ARB_IDLE: begin
        rearb = 1'b1;
        if (HTRANS == TRANS_NONSEQ && fixed_burst) begin
          trk_state = ARB_BURST;
          trk_count = burst_load;
        end else begin
          trk_state = ARB_IDLE;
          trk_count = 5'd0;
        end
      end
      ARB_BURST: begin
        case (HTRANS)
          TRANS_SEQ: begin
            if (count == 5'd1) begin
              rearb     = 1'b1;
              trk_state = ARB_IDLE;
              trk_count = 5'd0;
            end else begin
              trk_count = count - 5'd1;
            end
          end
          TRANS_BUSY: begin
            trk_count = count;
          end
          TRANS_NONSEQ: begin
            rearb = 1'b1;
            if (fixed_burst) begin
              trk_state = ARB_BURST;
              trk_count = burst_load;
            end else begin
              trk_state = ARB_IDLE;
              trk_count = 5'd0;
            end
          end
          default: begin
            rearb     = 1'b1;
            trk_state = ARB_IDLE;
            trk_count = 5'd0;
          end
        endcase
      end
      ARB_LOCKED: begin
        // Leaving the lock only returns to idle; the next idle edge rearbitrates.
        if (!HLOCK[owner]) begin
          trk_state = ARB_IDLE;
          trk_count = 5'd0;
        end
      end
      default: begin
        trk_state = ARB_IDLE;
        trk_count = 5'd0;
      end
    endcase
  end

  assign lock_keep = rearb && HLOCK[owner] && HBUSREQ[owner];

  // Search owner+1 upward, owner last; nothing requesting parks on master 0.
  always_comb begin
    rr_found = 1'b0;
    rr_next  = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(owner) + i) % NUM_MASTERS);
      if (!rr_found && HBUSREQ[cand]) begin
        rr_found = 1'b1;
        rr_next  = cand;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ARB_IDLE;
      count     <= 5'd0;
      owner     <= '0;
      HGRANT    <= NUM_MASTERS'(1);
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= owner;
      HMASTLOCK <= HLOCK[owner];
      if (lock_keep) begin
        state <= ARB_LOCKED;
        count <= 5'd0;
      end else begin
        state <= trk_state;
        count <= trk_count;
        if (rearb) begin
          owner  <= rr_next;
          HGRANT <= NUM_MASTERS'(1) << rr_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bus_arbiter
// Brief    : Directed + randomized bench for ahb_bus_arbiter with a beat-count model.
// Revision : 1.0
// ============================================================================
module tb_ahb_bus_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [N-1:0]  HBUSREQ;
  logic [N-1:0]  HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic          HMASTLOCK;

  always #5 ACLK = ~ACLK;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MW(MW)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner index, SEQ beats still owed, lock flag.
  int m_owner  = 0;
  int m_left   = 0;
  bit m_locked = 1'b0;
  int m_master = 0;
  bit m_mlock  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      3'b110, 3'b111: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [N-1:0] grant_of(input int idx);
    logic [N-1:0] g;
    g = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

  task automatic model_edge();
    int  nl;
    bit  rearb;
    int  pick;
    int  c;
    if (ARESET) begin
      m_owner = 0; m_left = 0; m_locked = 1'b0; m_master = 0; m_mlock = 1'b0;
      return;
    end
    if (!HREADY) return;
    m_master = m_owner;
    m_mlock  = HLOCK[m_owner];
    if (m_locked) begin
      if (!HLOCK[m_owner]) m_locked = 1'b0;
      return;
    end
    if (m_left == 0) rearb = 1'b1;
    else if (HTRANS == T_SEQ) rearb = (m_left == 1);
    else rearb = (HTRANS != T_BUSY);
    case (HTRANS)
      T_NONSEQ: nl = beats_of(HBURST) - 1;
      T_SEQ:    nl = (m_left > 0) ? m_left - 1 : 0;
      T_BUSY:   nl = m_left;
      default:  nl = 0;
    endcase
    if (rearb && HLOCK[m_owner] && HBUSREQ[m_owner]) begin
      m_locked = 1'b1;
      m_left   = 0;
      return;
    end
    m_left = nl;
    if (rearb) begin
      pick = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_owner + k) % N;
        if (HBUSREQ[c]) begin
          pick = c;
          break;
        end
      end
      m_owner = pick;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_edge();
    #1;
    chk("hgrant", HGRANT, grant_of(m_owner));
    chk("hmaster", HMASTER, m_master);
    chk("hmastlock", HMASTLOCK, m_mlock);
    chk("onehot", $onehot(HGRANT), 1);
  endtask

  logic [N-1:0] rr_exp [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int r;

  initial begin
    ARESET = 1'b1; HBUSREQ = 4'hF; HLOCK = '0; HTRANS = T_IDLE; HBURST = 3'b000; HREADY = 1'b1;

    repeat (3) begin
      tick();
      chk("rst_grant", HGRANT, 4'b0001);
    end
    chk("rst_master", HMASTER, 0);
    chk("rst_mlock", HMASTLOCK, 0);
    ARESET = 1'b0;
    tick();
    chk("post_rst_grant", HGRANT, 4'b0010);

    HTRANS = T_NONSEQ; HBURST = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", HGRANT, rr_exp[i]);
      chk("rr_master", HMASTER, (i + 1) % 4);
    end

    HBUSREQ = 4'b0000; HTRANS = T_IDLE;
    tick();
    chk("park", HGRANT, 4'b0001);

    HBUSREQ = 4'b0110; HTRANS = T_NONSEQ; HBURST = 3'b011;
    tick(); chk("burst_start", HGRANT, 4'b0010);
    HTRANS = T_SEQ;
    tick(); chk("burst_seq1", HGRANT, 4'b0010);
    HREADY = 1'b0;
    repeat (2) begin
      tick(); chk("burst_stall", HGRANT, 4'b0010);
    end
    HREADY = 1'b1;
    tick(); chk("burst_seq2", HGRANT, 4'b0010);
    tick(); chk("burst_end", HGRANT, 4'b0100);

    HBUSREQ = 4'hF; HLOCK = 4'b0100; HTRANS = T_NONSEQ;
    tick();
    chk("lock_grant", HGRANT, 4'b0100);
    chk("lock_mlock", HMASTLOCK, 1);
    for (int k = 0; k < 11; k++) begin
      HTRANS = (k % 4 == 3) ? T_NONSEQ : T_SEQ;
      tick();
      chk("lock_hold", HGRANT, 4'b0100);
      chk("lock_mlock", HMASTLOCK, 1);
    end
    HLOCK = 4'b0000; HTRANS = T_IDLE;
    tick(); chk("lock_drop_hold", HGRANT, 4'b0100);
    tick(); chk("lock_release", HGRANT, 4'b1000);

    HBUSREQ = 4'b1000; HTRANS = T_NONSEQ; HBURST = 3'b101;
    tick(); chk("incr8_start", HGRANT, 4'b1000);
    HTRANS = T_SEQ;
    tick(); chk("incr8_beat2", HGRANT, 4'b1000);
    HBUSREQ = 4'b0001; HTRANS = T_IDLE;
    tick(); chk("early_term", HGRANT, 4'b0001);
    tick(); chk("after_term", HGRANT, 4'b0001);

    HBUSREQ = 4'b1000; HTRANS = T_NONSEQ; HBURST = 3'b111;
    tick(); chk("incr16_start", HGRANT, 4'b1000);
    HTRANS = T_SEQ;
    repeat (2) tick();
    ARESET = 1'b1; HREADY = 1'b0;
    tick();
    chk("rst_mid_grant", HGRANT, 4'b0001);
    chk("rst_mid_master", HMASTER, 0);
    chk("rst_mid_mlock", HMASTLOCK, 0);
    ARESET = 1'b0; HREADY = 1'b1;
    tick(); chk("post_rst_rearb", HGRANT, 4'b1000);

    for (int i = 0; i < 800; i++) begin
      ARESET  = ($urandom_range(0, 99) == 0);
      HBUSREQ = 4'($urandom);
      if ($urandom_range(0, 7) == 0)
        HLOCK = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
      r = int'($urandom_range(0, 9));
      HTRANS  = (r < 5) ? T_SEQ : (r == 5) ? T_BUSY : (r < 8) ? T_NONSEQ : T_IDLE;
      HBURST  = 3'($urandom);
      HREADY  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of AHB requesters sharing the bus; legal range 2..8.
REQ-002 SHALL have parameter MW, default clog2(NUM_MASTERS), width of HMASTER.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port HBUSREQ  input  NUM_MASTERS  per-master bus request.
REQ-006 SHALL have port HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
REQ-007 SHALL have port HTRANS  input  2  muxed bus transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port HBURST  input  3  muxed bus burst type.
REQ-009 SHALL have port HREADY  input  1  muxed bus ready; high = address/data phase accepted.
REQ-010 SHALL have port HGRANT  output  NUM_MASTERS  one-hot grant, registered.
REQ-011 SHALL have port HMASTER  output  MW  index of master owning current address phase, registered.
REQ-012 SHALL have port HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-013 State register SHALL take values ARB_IDLE (no fixed burst open), ARB_BURST (fixed-length burst counting), ARB_LOCKED (owner holds lock).
REQ-014 All state/outputs SHALL update only on ACLK edges with HREADY=1, except reset.
REQ-015 Beat counter SHALL be 5 bits; at an edge with HREADY=1, HTRANS=NONSEQ: load L-1 for HBURST INCR4/WRAP4 (L=4), INCR8/WRAP8 (8), INCR16/WRAP16 (16) and go ARB_BURST; SINGLE/INCR leave ARB_IDLE.
REQ-016 In ARB_BURST, edge with HREADY=1, HTRANS=SEQ SHALL decrement counter; when counter==1 at that edge -> ARB_IDLE, counter 0.
REQ-017 BUSY SHALL not decrement; HTRANS=IDLE or NONSEQ inside ARB_BURST (early termination) SHALL abandon the burst (IDLE -> ARB_IDLE; NONSEQ reloads per REQ-015).
REQ-018 Rearbitration point SHALL be an edge with HREADY=1 and (state=ARB_IDLE, or state=ARB_BURST with HTRANS=SEQ and counter==1, or REQ-017 termination).
REQ-019 At a rearbitration point the owner SHALL keep grant if HLOCK[owner]=1 and HBUSREQ[owner]=1 (state -> ARB_LOCKED); ARB_LOCKED exits to ARB_IDLE at the first HREADY=1 edge with HLOCK[owner]=0.
REQ-020 Otherwise grant SHALL go round-robin: search HBUSREQ from owner+1 upward, wrapping modulo NUM_MASTERS, owner checked last.
REQ-021 With no HBUSREQ asserted, HGRANT SHALL park on master 0.
REQ-022 Outside rearbitration points HGRANT SHALL hold, regardless of HBUSREQ changes.
REQ-023 HMASTER SHALL load index(HGRANT) and HMASTLOCK SHALL load HLOCK[granted] at each HREADY=1 edge, i.e. one accepted cycle after HGRANT changes.
REQ-024 HREADY=0 SHALL freeze counter, state, HGRANT, HMASTER, HMASTLOCK.
REQ-025 HGRANT SHALL be exactly one-hot at all times.

Reset
REQ-026 ARESET=1 at an edge SHALL set HGRANT=one-hot master 0, HMASTER=0, HMASTLOCK=0, state=ARB_IDLE, counter=0, round-robin owner=0, independent of HREADY.
REQ-027 Reset mid-burst or mid-lock SHALL discard burst/lock context; first post-reset edge arbitrates per REQ-018..021.

Verification
REQ-028 Reset: ARESET high 3 cycles, HBUSREQ=1111 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0; after release HGRANT=0010 at first HREADY edge.
REQ-029 Round robin: HBUSREQ=1111, SINGLE NONSEQ each cycle, HREADY=1 -> HGRANT sequence 0001,0010,0100,1000,0001; HMASTER lags one cycle.
REQ-030 Fixed burst: master 1 INCR4 (NONSEQ+3 SEQ), HBUSREQ=0110 -> HGRANT stays 0010 through 3rd SEQ edge, 0100 after it; HREADY=0 for 2 cycles mid-burst extends hold by 2 cycles.
REQ-031 Lock: master 2 HLOCK=1, HBUSREQ=1111, three INCR4 bursts -> HGRANT=0100 and HMASTLOCK=1 throughout; HLOCK drop -> grant 1000 at next rearbitration.
REQ-032 Early termination: INCR8 by master 3, HTRANS=IDLE after 2 beats, HBUSREQ=0001 -> state ARB_IDLE, HGRANT=0001 at that edge.
REQ-033 Park/reset mid-burst: HBUSREQ=0000 -> HGRANT=0001; ARESET during INCR16 of master 3 -> reset values next edge, counter=0.
